// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Owns the single write port of the 32x32 register file. The in-order
//   pipeline writeback always has priority. Late load data returned after a
//   cache miss is queued in a small FIFO and drains on cycles the pipeline
//   leaves the port idle. A per-register busy scoreboard stalls decode on
//   hazards against loads that are still outstanding.
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   pipe_we/pipe_a3/pipe_wd         pipeline writeback (we==0 or a3==0: none)
//   mem_valid/mem_we/mem_a3/mem_wd  late load write, accepted when mem_ready
//   mem_ready                       FIFO has room (count < DEPTH)
//   issue_valid/issue_rd            long-latency load issued, marks rd busy
//   rs1, rs2                        decode source registers
//   stall                           hazard / backpressure stall to pipeline
//   rf_we3/rf_a3/rf_wd3             registered register-file write port
//   busy_vec                        scoreboard, bit 0 always 0
//   fifo_count                      late-write FIFO occupancy
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    pipe_we,
  input  logic [4:0]    pipe_a3,
  input  logic [31:0]   pipe_wd,
  input  logic          mem_valid,
  input  logic [2:0]    mem_we,
  input  logic [4:0]    mem_a3,
  input  logic [31:0]   mem_wd,
  output logic          mem_ready,
  input  logic          issue_valid,
  input  logic [4:0]    issue_rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  output logic          stall,
  output logic [2:0]    rf_we3,
  output logic [4:0]    rf_a3,
  output logic [31:0]   rf_wd3,
  output logic [31:0]   busy_vec,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry layout: {we[2:0], a3[4:0], wd[31:0]}
  logic [39:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   busy_reg;
  logic [31:0]   busy_next;

  logic          pipe_write;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          issue_set;
  logic [39:0]   head;
  logic [2:0]    head_we;
  logic [4:0]    head_a3;
  logic [31:0]   head_wd;
  logic [3:0]    hz;

  assign pipe_write = (pipe_we != 3'd0) && (pipe_a3 != 5'd0);
  assign fifo_empty = (count_reg == '0);
  assign mem_ready  = (count_reg < CW'(DEPTH));
  // A push while full is a protocol violation; it is simply dropped here.
  assign push       = mem_valid && mem_ready;
  // The FIFO only gets the port when the pipeline does not want it.
  assign pop        = !pipe_write && !fifo_empty;
  assign issue_set  = issue_valid && (issue_rd != 5'd0);

  assign head    = fifo_mem[rd_ptr_reg];
  assign head_we = head[39:37];
  assign head_a3 = head[36:32];
  assign head_wd = head[31:0];

  // Hazard sources: RAW on either source, WAW on a new load destination,
  // and a full FIFO. The full-FIFO term forces pipeline bubbles so the
  // queued late writes are guaranteed to win the port eventually.
  assign hz[0] = (rs1 != 5'd0) && busy_reg[rs1];
  assign hz[1] = (rs2 != 5'd0) && busy_reg[rs2];
  assign hz[2] = issue_set && busy_reg[issue_rd];
  assign hz[3] = (count_reg == CW'(DEPTH));
  assign stall = |hz;

  assign busy_vec   = busy_reg;
  assign fifo_count = count_reg;

  // Scoreboard next state per register. Setting takes priority over the
  // clear from a pop so a re-issued load to the same register stays tracked.
  assign busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_next[gi] = (issue_set && (issue_rd == 5'(gi))) ||
                             (busy_reg[gi] && !(pop && (head_a3 == 5'(gi))));
    end
  endgenerate

  // FIFO storage carries no reset; validity is tracked by count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {mem_we, mem_a3, mem_wd};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      busy_reg   <= '0;
      rf_we3     <= 3'd0;
      rf_a3      <= 5'd0;
      rf_wd3     <= 32'd0;
    end else begin
      busy_reg <= busy_next;

      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);

      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase

      if (pipe_write) begin
        rf_we3 <= pipe_we;
        rf_a3  <= pipe_a3;
        rf_wd3 <= pipe_wd;
      end else if (pop) begin
        rf_we3 <= head_we;
        rf_a3  <= head_a3;
        rf_wd3 <= head_wd;
      end else begin
        // Address and data hold; only the enable drops.
        rf_we3 <= 3'd0;
      end
    end
  end

  // Protocol checks (simulation only).
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
                                   !(mem_valid && !mem_ready));
  a_mem_we      : assert property (@(posedge clk) disable iff (rst)
                                   mem_valid |-> (mem_we != 3'd0));
  a_pipe_busy   : assert property (@(posedge clk) disable iff (rst)
                                   pipe_write |-> !busy_reg[pipe_a3]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: a hand-computed vector table, a few
// multi-cycle corner sequences, then randomized traffic checked against a
// queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    pipe_we = '0;
  logic [4:0]    pipe_a3 = '0;
  logic [31:0]   pipe_wd = '0;
  logic          mem_valid = 1'b0;
  logic [2:0]    mem_we = '0;
  logic [4:0]    mem_a3 = '0;
  logic [31:0]   mem_wd = '0;
  logic          mem_ready;
  logic          issue_valid = 1'b0;
  logic [4:0]    issue_rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic          stall;
  logic [2:0]    rf_we3;
  logic [4:0]    rf_a3;
  logic [31:0]   rf_wd3;
  logic [31:0]   busy_vec;
  logic [CW-1:0] fifo_count;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_a3(mem_a3), .mem_wd(mem_wd),
    .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .rf_we3(rf_we3), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .busy_vec(busy_vec), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending late writes as a queue, busy as a bit per register.
  typedef struct {
    logic [2:0]  we;
    logic [4:0]  a3;
    logic [31:0] wd;
  } ent_t;
  ent_t        q[$];
  logic [31:0] m_busy = '0;
  logic [2:0]  e_we = '0;
  logic [4:0]  e_a3 = '0;
  logic [31:0] e_wd = '0;

  typedef struct {
    logic [2:0] pwe; logic [4:0] pa3; logic [31:0] pwd;
    logic mv; logic [2:0] mwe; logic [4:0] ma3; logic [31:0] mwd;
    logic iv; logic [4:0] ird; logic [4:0] r1; logic [4:0] r2;
    logic xs; logic [2:0] xwe; logic [4:0] xa3; logic [31:0] xwd;
    logic [1:0] xcnt; logic [31:0] xbusy;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [2:0] pwe, input logic [4:0] pa3, input logic [31:0] pwd,
                        input logic mv, input logic [2:0] mwe, input logic [4:0] ma3,
                        input logic [31:0] mwd, input logic iv, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2);
    pipe_we = pwe; pipe_a3 = pa3; pipe_wd = pwd;
    mem_valid = mv; mem_we = mwe; mem_a3 = ma3; mem_wd = mwd;
    issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: check combinational outputs against the model, advance the
  // model by the arbitration rules, then check registered outputs.
  task automatic cycle(input string tag);
    int   sz;
    bit   pw;
    bit   xs;
    ent_t e;
    sz = q.size();
    #1;
    xs = ((rs1 != 0) && m_busy[rs1]) || ((rs2 != 0) && m_busy[rs2]) ||
         (issue_valid && (issue_rd != 0) && m_busy[issue_rd]) || (sz == DEPTH);
    chk({tag, " mem_ready"}, 32'(mem_ready), 32'(sz < DEPTH));
    chk({tag, " stall"}, 32'(stall), 32'(xs));
    pw = (pipe_we != 0) && (pipe_a3 != 0);
    if (pw) begin
      e_we = pipe_we; e_a3 = pipe_a3; e_wd = pipe_wd;
    end else if (sz > 0) begin
      e = q.pop_front();
      e_we = e.we; e_a3 = e.a3; e_wd = e.wd;
      m_busy[e.a3] = 1'b0;
    end else begin
      e_we = 3'd0;
    end
    if (mem_valid && (sz < DEPTH)) begin
      e.we = mem_we; e.a3 = mem_a3; e.wd = mem_wd;
      q.push_back(e);
    end
    if (issue_valid && (issue_rd != 0)) m_busy[issue_rd] = 1'b1;
    m_busy[0] = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " rf_we3"}, 32'(rf_we3), 32'(e_we));
    chk({tag, " rf_a3"}, 32'(rf_a3), 32'(e_a3));
    chk({tag, " rf_wd3"}, rf_wd3, e_wd);
    chk({tag, " fifo_count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, " busy_vec"}, busy_vec, m_busy);
    $display("[%0t] %s we=%0d a3=%0d wd=%h cnt=%0d busy=%h stall_in=%0d",
             $time, tag, rf_we3, rf_a3, rf_wd3, fifo_count, busy_vec, xs);
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = '0;
    e_we = '0; e_a3 = '0; e_wd = '0;
  endtask

  initial begin
    tbl[0] = '{0,0,0,            0,0,0,0,             1,7, 0,0, 0, 0,0,0,            0, 32'h80};
    tbl[1] = '{0,0,0,            1,2,7,32'hDEADBEEF,  0,0, 7,0, 1, 0,0,0,            1, 32'h80};
    tbl[2] = '{0,0,0,            0,0,0,0,             0,0, 7,0, 1, 2,7,32'hDEADBEEF, 0, 32'h0};
    tbl[3] = '{0,0,0,            0,0,0,0,             0,0, 7,0, 0, 0,7,32'hDEADBEEF, 0, 32'h0};
    tbl[4] = '{0,0,0,            0,0,0,0,             1,9, 0,0, 0, 0,7,32'hDEADBEEF, 0, 32'h200};
    tbl[5] = '{1,3,32'h11,       1,2,9,32'h22,        0,0, 0,0, 0, 1,3,32'h11,       1, 32'h200};
    tbl[6] = '{1,3,32'h11,       0,0,0,0,             0,0, 0,9, 1, 1,3,32'h11,       1, 32'h200};
    tbl[7] = '{1,3,32'h11,       0,0,0,0,             0,0, 0,0, 0, 1,3,32'h11,       1, 32'h200};
    tbl[8] = '{0,0,0,            0,0,0,0,             0,0, 0,0, 0, 2,9,32'h22,       0, 32'h0};
    tbl[9] = '{5,0,32'h55,       0,0,0,0,             0,0, 0,0, 0, 0,9,32'h22,       0, 32'h0};

    // Reset state
    @(posedge clk); #1;
    chk("reset rf_we3", 32'(rf_we3), 0);
    chk("reset rf_a3", 32'(rf_a3), 0);
    chk("reset rf_wd3", rf_wd3, 0);
    chk("reset busy_vec", busy_vec, 0);
    chk("reset fifo_count", 32'(fifo_count), 0);
    chk("reset mem_ready", 32'(mem_ready), 1);
    rst = 1'b0;

    // Table: lone late write, RAW stall, pipe/mem collision
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].pwe, tbl[i].pa3, tbl[i].pwd, tbl[i].mv, tbl[i].mwe, tbl[i].ma3,
             tbl[i].mwd, tbl[i].iv, tbl[i].ird, tbl[i].r1, tbl[i].r2);
      #1;
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'(tbl[i].xs));
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d rf_we3", i), 32'(rf_we3), 32'(tbl[i].xwe));
      chk($sformatf("vec%0d rf_a3", i), 32'(rf_a3), 32'(tbl[i].xa3));
      chk($sformatf("vec%0d rf_wd3", i), rf_wd3, tbl[i].xwd);
      chk($sformatf("vec%0d fifo_count", i), 32'(fifo_count), 32'(tbl[i].xcnt));
      chk($sformatf("vec%0d busy_vec", i), busy_vec, tbl[i].xbusy);
    end

    // Full FIFO: pipe writes continuously while two late writes queue up
    set_in(1, 3, 32'h11, 1, 1, 10, 32'hA, 0, 0, 0, 0); cycle("full_a");
    set_in(1, 3, 32'h11, 1, 1, 11, 32'hB, 0, 0, 0, 0); cycle("full_b");
    set_in(1, 3, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("full mem_ready", 32'(mem_ready), 0);
    chk("full stall", 32'(stall), 1);
    cycle("full_c");
    idle(); cycle("full_d");
    chk("full pop1 a3", 32'(rf_a3), 10);
    chk("full ready back", 32'(mem_ready), 1);
    cycle("full_e");
    chk("full pop2 a3", 32'(rf_a3), 11);

    // Reset mid-operation with two queued entries and busy[5]
    set_in(1, 3, 32'h11, 1, 1, 12, 32'hC, 1, 5, 0, 0); cycle("rst_a");
    set_in(1, 3, 32'h11, 1, 1, 13, 32'hD, 0, 0, 0, 0); cycle("rst_b");
    idle();
    #3;
    rst = 1'b1;
    #1;
    chk("midrst rf_we3", 32'(rf_we3), 0);
    chk("midrst rf_a3", 32'(rf_a3), 0);
    chk("midrst rf_wd3", rf_wd3, 0);
    chk("midrst busy_vec", busy_vec, 0);
    chk("midrst fifo_count", 32'(fifo_count), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // Same-cycle set and clear of x6: the set wins
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0); cycle("sc_a");
    set_in(0, 0, 0, 1, 4, 6, 32'h66, 0, 0, 0, 0); cycle("sc_b");
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0); cycle("sc_c");
    chk("setclr rf_a3", 32'(rf_a3), 6);
    chk("setclr busy6", 32'(busy_vec[6]), 1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      pipe_we   = ($urandom_range(0, 9) < 4) ? 3'($urandom_range(1, 7)) : 3'd0;
      pipe_a3   = 5'($urandom);
      pipe_wd   = $urandom;
      if (m_busy[pipe_a3]) pipe_we = 3'd0;
      mem_valid = (q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
      mem_we    = 3'($urandom_range(1, 7));
      mem_a3    = 5'($urandom);
      mem_wd    = $urandom;
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd  = 5'($urandom);
      rs1       = 5'($urandom);
      rs2       = 5'($urandom);
      cycle($sformatf("rnd%0d", n));
    end
    idle();
    for (int n = 0; n < 4; n++) cycle($sformatf("drain%0d", n));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
